// File: rtl/divider.sv
// Multi-cycle restoring divider for DIV/DIVU in byte (16/8) and word (32/16) sizes.
// One quotient bit per clock on operand magnitudes, followed by sign correction and range checks.
module divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        size,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2,
        FIX   = 2'd3
    } state_t;

    state_t      state_q;
    logic        size_q;
    logic        sgn_q;
    logic [31:0] dvd_q;
    logic [15:0] dvs_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [15:0] dmag_q;
    logic [15:0] rem_q;
    logic [15:0] dq_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] quot_q;
    logic [15:0] rmd_q;

    logic        dvd_neg_d;
    logic        dvs_neg_d;
    logic [31:0] dvd_mag_d;
    logic [15:0] dvs_mag_d;
    logic [15:0] upper_d;
    logic [15:0] lower_d;
    logic        setup_err_d;
    logic [16:0] trial_d;
    logic        qbit_d;
    logic [15:0] rem_d;
    logic [15:0] dq_d;
    logic [15:0] qmag_d;
    logic [15:0] qres_d;
    logic [15:0] rres_d;
    logic [15:0] lim_d;
    logic        range_err_d;
    logic [15:0] quot_d;
    logic [15:0] rmd_d;

    // Operand magnitudes and the SETUP-time overflow test
    always_comb begin
        dvd_neg_d = sgn_q & (size_q ? dvd_q[31] : dvd_q[15]);
        dvs_neg_d = sgn_q & (size_q ? dvs_q[15] : dvs_q[7]);
        if (size_q) begin
            dvd_mag_d = dvd_neg_d ? (~dvd_q + 32'd1) : dvd_q;
            dvs_mag_d = dvs_neg_d ? (~dvs_q + 16'd1) : dvs_q;
            upper_d   = dvd_mag_d[31:16];
            lower_d   = dvd_mag_d[15:0];
        end else begin
            dvd_mag_d = {16'h0000, dvd_neg_d ? (~dvd_q[15:0] + 16'd1) : dvd_q[15:0]};
            dvs_mag_d = {8'h00, dvs_neg_d ? (~dvs_q[7:0] + 8'd1) : dvs_q[7:0]};
            upper_d   = {8'h00, dvd_mag_d[15:8]};
            // Byte-mode low half sits at the top so the same MSB-first shift serves both sizes
            lower_d   = {dvd_mag_d[7:0], 8'h00};
        end
        setup_err_d = (dvs_mag_d == 16'h0000) || (upper_d >= dvs_mag_d);
    end

    // One restoring step: partial remainder stays below the divisor, so 17 bits suffice for the trial
    always_comb begin
        trial_d = {rem_q, dq_q[15]};
        qbit_d  = (trial_d >= {1'b0, dmag_q});
        rem_d   = qbit_d ? (trial_d[15:0] - dmag_q) : trial_d[15:0];
        dq_d    = {dq_q[14:0], qbit_d};
    end

    // Sign correction and signed range check on the finished magnitudes
    always_comb begin
        qmag_d      = size_q ? dq_q : {8'h00, dq_q[7:0]};
        qres_d      = qneg_q ? (~qmag_d + 16'd1) : qmag_d;
        rres_d      = rneg_q ? (~rem_q + 16'd1) : rem_q;
        lim_d       = size_q ? 16'h8000 : 16'h0080;
        range_err_d = sgn_q & (qneg_q ? (qmag_d > lim_d) : (qmag_d >= lim_d));
        quot_d      = size_q ? qres_d : {8'h00, qres_d[7:0]};
        rmd_d       = size_q ? rres_d : {8'h00, rres_d[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            size_q  <= 1'b0;
            sgn_q   <= 1'b0;
            dvd_q   <= 32'h0;
            dvs_q   <= 16'h0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dmag_q  <= 16'h0;
            rem_q   <= 16'h0;
            dq_q    <= 16'h0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            quot_q  <= 16'h0;
            rmd_q   <= 16'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        size_q  <= size;
                        sgn_q   <= is_signed;
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    qneg_q <= dvd_neg_d ^ dvs_neg_d;
                    rneg_q <= dvd_neg_d;
                    dmag_q <= dvs_mag_d;
                    rem_q  <= upper_d;
                    dq_q   <= lower_d;
                    cnt_q  <= size_q ? 4'd15 : 4'd7;
                    if (setup_err_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    rem_q <= rem_d;
                    dq_q  <= dq_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= range_err_d;
                    if (!range_err_d) begin
                        quot_q <= quot_d;
                        rmd_q  <= rmd_d;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_error = err_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;

endmodule
